// File: rtl/rrf_flag_commit.sv
`default_nettype none
// ============================================================================
//  Module   : rrf_flag_commit
//  Purpose  : Retire-side commit stage in front of the retired flag register
//             file. Registers one retire group per cycle (S1), picks the
//             youngest completed flag writer that precedes the first excepting
//             slot (S2, combinational), and drives the flag file's single
//             write port from an output register. A per-thread shadow of the
//             committed flags answers post-flush restore requests one cycle
//             after the request.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             ret_en/ret_thread   - retire group strobe and its thread
//             ret_vld/fwr/exc     - per-slot valid, flag-write, exception
//             ret_data            - per-slot flag results, slot i at
//                                   [i*DATA_WIDTH +: DATA_WIDTH]
//             wr_data/wen/thread  - flag-file write port
//             rst_req/rst_thread  - restore request and thread
//             rst_data/rst_valid  - restored flags, valid one cycle later
//             commit_cnt          - wrapping count of flag-file writes
//  Revision : 1.0 - initial release
// ============================================================================
module rrf_flag_commit #(
    parameter int DATA_WIDTH = 6,
    parameter int SLOTS      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ret_en,
    input  logic                        ret_thread,
    input  logic [SLOTS-1:0]            ret_vld,
    input  logic [SLOTS-1:0]            ret_fwr,
    input  logic [SLOTS-1:0]            ret_exc,
    input  logic [SLOTS*DATA_WIDTH-1:0] ret_data,
    output logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        wr_wen,
    output logic                        wr_thread,
    input  logic                        rst_req,
    input  logic                        rst_thread,
    output logic [DATA_WIDTH-1:0]       rst_data,
    output logic                        rst_valid,
    output logic [CNT_WIDTH-1:0]        commit_cnt
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // S1: registered retire group
    // ------------------------------------------------------------------------
    logic                        r_s1_valid;
    logic                        r_s1_thread;
    logic [SLOTS-1:0]            r_s1_vld;
    logic [SLOTS-1:0]            r_s1_fwr;
    logic [SLOTS-1:0]            r_s1_exc;
    logic [SLOTS*DATA_WIDTH-1:0] r_s1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_thread <= 1'b0;
            r_s1_vld    <= '0;
            r_s1_fwr    <= '0;
            r_s1_exc    <= '0;
            r_s1_data   <= '0;
        end else if (ret_en) begin
            r_s1_valid  <= 1'b1;
            r_s1_thread <= ret_thread;
            r_s1_vld    <= ret_vld;
            r_s1_fwr    <= ret_fwr;
            r_s1_exc    <= ret_exc;
            r_s1_data   <= ret_data;
        end else begin
            // Payload is held; only the valid bit drops.
            r_s1_valid  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // S2: candidate selection
    // A slot survives only if no slot at or before it raised an exception.
    // ------------------------------------------------------------------------
    logic [SLOTS-1:0]      w_cand;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_hit;

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic w_alive;
            assign w_alive    = r_s1_vld[gi] & ~(|r_s1_exc[gi:0]);
            assign w_cand[gi] = w_alive & r_s1_fwr[gi];
        end
    endgenerate

    // Ascending scan: the youngest (highest-index) candidate wins.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (w_cand[i]) begin
                w_sel_data = r_s1_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_hit = r_s1_valid & (|w_cand);

    // ------------------------------------------------------------------------
    // Write port, shadow, statistic counter, restore
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_wr_wen;
    logic                  r_wr_thread;
    logic [DATA_WIDTH-1:0] r_shadow [0:1];
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_rst_data;
    logic                  r_rst_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_data   <= '0;
            r_wr_wen    <= 1'b0;
            r_wr_thread <= 1'b0;
            r_shadow[0] <= '0;
            r_shadow[1] <= '0;
            r_cnt       <= '0;
        end else begin
            r_wr_wen    <= w_hit;
            r_wr_thread <= r_s1_thread;
            if (w_hit) begin
                r_wr_data             <= w_sel_data;
                r_shadow[r_s1_thread] <= w_sel_data;
                r_cnt                 <= r_cnt + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_data  <= '0;
            r_rst_valid <= 1'b0;
        end else begin
            r_rst_valid <= rst_req;
            if (rst_req) begin
                // Bypass a shadow write to the same thread landing this edge.
                if (w_hit && (r_s1_thread == rst_thread)) begin
                    r_rst_data <= w_sel_data;
                end else begin
                    r_rst_data <= r_shadow[rst_thread];
                end
            end
        end
    end

    assign wr_data    = r_wr_data;
    assign wr_wen     = r_wr_wen;
    assign wr_thread  = r_wr_thread;
    assign rst_data   = r_rst_data;
    assign rst_valid  = r_rst_valid;
    assign commit_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rrf_flag_commit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rrf_flag_commit
//  Purpose  : Self-checking bench for rrf_flag_commit. Directed scenarios with
//             literal expectations, then randomized traffic compared every
//             cycle against a behavioural model of the commit rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rrf_flag_commit;

    localparam int DW = 6;
    localparam int SL = 4;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             ret_en;
    logic             ret_thread;
    logic [SL-1:0]    ret_vld;
    logic [SL-1:0]    ret_fwr;
    logic [SL-1:0]    ret_exc;
    logic [SL*DW-1:0] ret_data;
    logic [DW-1:0]    wr_data;
    logic             wr_wen;
    logic             wr_thread;
    logic             rst_req;
    logic             rst_thread;
    logic [DW-1:0]    rst_data;
    logic             rst_valid;
    logic [CW-1:0]    commit_cnt;

    rrf_flag_commit #(.DATA_WIDTH(DW), .SLOTS(SL), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ret_en     (ret_en),
        .ret_thread (ret_thread),
        .ret_vld    (ret_vld),
        .ret_fwr    (ret_fwr),
        .ret_exc    (ret_exc),
        .ret_data   (ret_data),
        .wr_data    (wr_data),
        .wr_wen     (wr_wen),
        .wr_thread  (wr_thread),
        .rst_req    (rst_req),
        .rst_thread (rst_thread),
        .rst_data   (rst_data),
        .rst_valid  (rst_valid),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    bit            m_init = 0;
    bit            m_grp_valid;
    bit            m_grp_thread;
    bit [SL-1:0]   m_grp_vld, m_grp_fwr, m_grp_exc;
    bit [DW-1:0]   m_grp_data [SL];
    bit            m_wen, m_thread, m_rv;
    bit [DW-1:0]   m_data, m_rd;
    bit [DW-1:0]   m_shadow [2];
    int unsigned   m_cnt;

    // Walk the group oldest to youngest; the first exception ends the walk,
    // and the last flag writer seen before that is the committed one.
    task automatic eval_group(output bit hit, output bit [DW-1:0] d);
        hit = 0;
        d   = '0;
        for (int i = 0; i < SL; i++) begin
            if (m_grp_exc[i]) break;
            if (m_grp_vld[i] && m_grp_fwr[i]) begin
                hit = 1;
                d   = m_grp_data[i];
            end
        end
        if (!m_grp_valid) hit = 0;
    endtask

    always @(posedge clk) begin
        bit          hit;
        bit [DW-1:0] d;
        if (rst) begin
            m_init       = 1;
            m_grp_valid  = 0;
            m_grp_thread = 0;
            m_wen = 0; m_thread = 0; m_data = '0;
            m_rv  = 0; m_rd = '0;
            m_shadow[0] = '0; m_shadow[1] = '0;
            m_cnt = 0;
        end else begin
            eval_group(hit, d);
            m_rv = rst_req;
            if (rst_req) m_rd = (hit && m_grp_thread == rst_thread) ? d : m_shadow[rst_thread];
            m_wen    = hit;
            m_thread = m_grp_thread;
            if (hit) begin
                m_data                 = d;
                m_shadow[m_grp_thread] = d;
                m_cnt                  = (m_cnt + 1) % (1 << CW);
            end
            if (ret_en) begin
                m_grp_valid  = 1;
                m_grp_thread = ret_thread;
                m_grp_vld    = ret_vld;
                m_grp_fwr    = ret_fwr;
                m_grp_exc    = ret_exc;
                for (int i = 0; i < SL; i++) m_grp_data[i] = ret_data[i*DW +: DW];
            end else begin
                m_grp_valid = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_init) begin
            n_vec++;
            if (wr_wen !== m_wen || wr_thread !== m_thread || wr_data !== m_data ||
                commit_cnt !== CW'(m_cnt) || rst_valid !== m_rv ||
                (m_rv && rst_data !== m_rd)) begin
                n_mis++;
                $display("FAIL model t=%0t: wen=%b/%b thr=%b/%b data=%h/%h cnt=%0d/%0d rv=%b/%b rd=%h/%h (actual/required)",
                         $time, wr_wen, m_wen, wr_thread, m_thread, wr_data, m_data,
                         commit_cnt, m_cnt, rst_valid, m_rv, rst_data, m_rd);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ret_en = 0; ret_thread = 0; ret_vld = '0; ret_fwr = '0; ret_exc = '0;
        ret_data = '0; rst_req = 0; rst_thread = 0;
    endtask

    task automatic group(input bit thr, input bit [SL-1:0] v, input bit [SL-1:0] f,
                         input bit [SL-1:0] e, input bit [SL*DW-1:0] d);
        ret_en = 1; ret_thread = thr; ret_vld = v; ret_fwr = f; ret_exc = e; ret_data = d;
    endtask

    task automatic restore(input bit thr, input bit [DW-1:0] exp, input string name);
        idle();
        rst_req = 1; rst_thread = thr;
        step();
        rst_req = 0;
        check({name, "_valid"}, 32'(rst_valid), 32'd1);
        check({name, "_data"}, 32'(rst_data), 32'(exp));
    endtask

    initial begin
        int n;
        idle();
        rst = 1;
        step(); step();
        rst = 0;

        // Reset state
        step();
        check("rst_wen", 32'(wr_wen), 32'd0);
        check("rst_wdata", 32'(wr_data), 32'd0);
        check("rst_cnt", 32'(commit_cnt), 32'd0);
        restore(1, 6'h00, "rst_restore_t1");

        // Youngest flag writer wins
        group(0, 4'b1111, 4'b0101, 4'b0000, {6'h04, 6'h03, 6'h02, 6'h01});
        step(); idle(); step();
        check("basic_wen", 32'(wr_wen), 32'd1);
        check("basic_data", 32'(wr_data), 32'h03);
        check("basic_thr", 32'(wr_thread), 32'd0);
        check("basic_cnt", 32'(commit_cnt), 32'd1);

        // Exception on slot 2 truncates the group
        group(0, 4'b1111, 4'b1111, 4'b0100, {6'h14, 6'h13, 6'h12, 6'h11});
        step(); idle(); step();
        check("exc2_wen", 32'(wr_wen), 32'd1);
        check("exc2_data", 32'(wr_data), 32'h12);
        // Exception on slot 0 kills the whole group
        group(0, 4'b1111, 4'b1111, 4'b0001, {6'h24, 6'h23, 6'h22, 6'h21});
        step(); idle(); step();
        check("exc0_wen", 32'(wr_wen), 32'd0);
        restore(0, 6'h12, "exc0_shadow");

        // Back-to-back same thread with restore bypass on the second write
        group(1, 4'b1000, 4'b1000, 4'b0000, {6'h2A, 18'h0});
        step();
        group(1, 4'b0001, 4'b0001, 4'b0000, {18'h0, 6'h15});
        step();
        check("b2b_first", 32'(wr_data), 32'h2A);
        idle();
        rst_req = 1; rst_thread = 1;
        step();
        rst_req = 0;
        check("b2b_second", 32'(wr_data), 32'h15);
        check("b2b_wen", 32'(wr_wen), 32'd1);
        check("bypass_valid", 32'(rst_valid), 32'd1);
        check("bypass_data", 32'(rst_data), 32'h15);

        // Interleaved threads
        group(0, 4'b0010, 4'b0010, 4'b0000, {12'h0, 6'h07, 6'h0});
        step();
        group(1, 4'b0100, 4'b0100, 4'b0000, {6'h0, 6'h38, 12'h0});
        step(); idle(); step();
        restore(0, 6'h07, "inter_t0");
        restore(1, 6'h38, "inter_t1");

        // Counter wrap: bring count to all-ones, then one more write
        n = 65535 - int'(m_cnt);
        for (int i = 0; i < n; i++) begin
            group(i[0], 4'b0001, 4'b0001, 4'b0000, 24'($urandom));
            step();
        end
        idle(); step(); step();
        check("cnt_ones", 32'(commit_cnt), 32'hFFFF);
        group(0, 4'b0001, 4'b0001, 4'b0000, 24'h1);
        step(); idle(); step();
        check("cnt_wrap", 32'(commit_cnt), 32'd0);

        // Reset while S1 holds a valid group
        group(1, 4'b1111, 4'b1111, 4'b0000, {6'h3F, 6'h3E, 6'h3D, 6'h3C});
        step();
        idle();
        rst = 1;
        step();
        rst = 0;
        check("midrst_wen", 32'(wr_wen), 32'd0);
        step();
        check("midrst_wen2", 32'(wr_wen), 32'd0);
        restore(0, 6'h00, "midrst_t0");
        restore(1, 6'h00, "midrst_t1");

        // Randomized traffic, checked by the per-cycle model compare
        for (int i = 0; i < 3000; i++) begin
            ret_en     = ($urandom_range(0, 3) != 0);
            ret_thread = 1'($urandom);
            ret_vld    = 4'($urandom);
            ret_fwr    = 4'($urandom);
            ret_exc    = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            ret_data   = 24'($urandom);
            rst_req    = ($urandom_range(0, 3) == 0);
            rst_thread = 1'($urandom);
            rst        = ($urandom_range(0, 199) == 0);
            step();
        end
        idle();
        rst = 0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rrf_flag_commit.md
Name: rrf_flag_commit

Overview:
- Retirement-side stage directly upstream of the retired flag register file.
- Each cycle takes one retire group of up to SLOTS instructions, oldest in slot 0.
- Picks the youngest completed flag-writing slot that precedes the first excepting slot, and produces that register file's single write port: data, write enable and thread.
- Keeps a per-thread shadow of committed flags. The shadow answers restore requests after a flush without a register-file read cycle.

Parameters:
DATA_WIDTH, 6, flag word width
SLOTS, 4, retire slots per group (slot 0 oldest)
CNT_WIDTH, 16, width of committed-write statistic counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ret_en  in  1  retire group presented this cycle
ret_thread  in  1  thread of the retire group
ret_vld  in  SLOTS  slot holds a retiring instruction
ret_fwr  in  SLOTS  slot instruction writes flags
ret_exc  in  SLOTS  slot instruction raised an exception
ret_data  in  SLOTS*DATA_WIDTH  flag result, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
wr_data  out  DATA_WIDTH  flag-file write data
wr_wen  out  1  flag-file write enable
wr_thread  out  1  flag-file write thread
rst_req  in  1  restore request after flush
rst_thread  in  1  thread to restore
rst_data  out  DATA_WIDTH  committed flags of the requested thread
rst_valid  out  1  rst_data valid
commit_cnt  out  CNT_WIDTH  count of flag-file writes, wraps

Behaviour:
- Reset (rst=1 at a posedge) clears:
  - all pipeline registers;
  - wr_data=0, wr_wen=0, wr_thread=0;
  - both shadows to 0;
  - rst_data=0, rst_valid=0, commit_cnt=0.
- Stage S1, at the posedge with ret_en=1:
  - register ret_thread, ret_vld, ret_fwr, ret_exc and ret_data.
  - ret_en=0: S1 valid cleared and all other fields held.
- Stage S2, combinational from S1:
  - alive[i] = vld[i] & ~exc[j] for all j<=i (an excepting slot and every slot after it are dropped).
  - cand[i] = alive[i] & fwr[i].
  - sel = highest i with cand[i]=1.
  - hit = S1 valid & |cand.
- Output register, at the posedge after S1 captures:
  - wr_wen <= hit; wr_thread <= S1 thread.
  - wr_data <= data[sel] when hit, else held.
- Latency: ret_en at edge N gives wr_wen=1 during the cycle after edge N+1 (2 cycles). Throughput is one group per cycle with no stall and no backpressure.
- Shadow update: on the same edge that sets wr_wen, shadow[S1 thread] <= data[sel]; commit_cnt increments by 1 and wraps at 2^CNT_WIDTH-1 -> 0.
- Restore: rst_req at edge M gives rst_valid=1 and rst_data valid for the cycle after edge M; rst_valid=0 otherwise.
  - If a shadow write to the same thread happens on edge M, rst_data returns the newly written value (bypass).
  - Restore does not disturb the S1, S2 or write pipeline; retired groups are always written.
- Back-to-back groups of the same thread: each group writes in its own cycle; the later group wins the shadow.
- All slots invalid, ret_fwr=0, or ret_exc on slot 0: wr_wen=0 and shadow unchanged.
- Reset mid-operation: in-flight groups are discarded with no write, and the shadow returns to 0.

Test Plan:
- rst=1 for 2 cycles, then idle -> wr_wen=0, wr_data=0, commit_cnt=0; rst_req for thread 1 -> rst_valid=1, rst_data=0.
- ret_en, thread 0, vld=1111, fwr=0101, data slots 0..3 = 01,02,03,04, no exc -> 2 cycles later wr_wen=1, wr_data=03, wr_thread=0; commit_cnt=1.
- vld=1111, fwr=1111, exc=0100 (slot 2), data slots 0..3 = 11,12,13,14 -> wr_data=12 (slot 1); in a second case exc on slot 0 -> wr_wen=0 and shadow unchanged.
- Consecutive groups: thread 1 slot 3 = 2A, then thread 1 slot 0 = 15 -> two consecutive writes, 2A then 15; rst_req thread 1 issued on the second write edge -> rst_data=15 (bypass).
- Interleaved threads (0 writes 07, 1 writes 38), then rst_req for each thread -> 07 and 38 respectively.
- Preload commit_cnt to all-ones via 65535 writes, then one more write -> commit_cnt wraps to 0.
- Assert rst while S1 holds a valid group -> no write in the following cycle; shadows read back 0.
